// File: rtl/alu_pkg.sv
// Shared encodings for the logic ALU and its operation scheduler.
package alu_pkg;

  localparam logic GRP_A = 1'b0;
  localparam logic GRP_B = 1'b1;

  localparam logic [1:0] OPA_AND  = 2'b00;
  localparam logic [1:0] OPA_NAND = 2'b01;
  localparam logic [1:0] OPA_OR   = 2'b10;
  localparam logic [1:0] OPA_XOR  = 2'b11;

  localparam logic [1:0] OPB_XNOR = 2'b00;
  localparam logic [1:0] OPB_AND  = 2'b01;
  localparam logic [1:0] OPB_NOR  = 2'b10;
  localparam logic [1:0] OPB_OR   = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StCapture,
    StClear,
    StResp
  } state_e;

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last served requester.
module alu_rr_arb2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_done,
  input  logic i_done_id,
  output logic o_gnt_valid,
  output logic o_gnt_id
);

  logic r_last;

  // Reset to "last served = 1" so requester 0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (i_done) begin
      r_last <= i_done_id;
    end
  end

  always_comb begin
    o_gnt_valid = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_gnt_id = ~r_last;
    end else begin
      o_gnt_id = i_req1;
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares the two-group logic ALU between two requesters and returns tagged responses.
module alu_op_scheduler
  import alu_pkg::*;
#(
  parameter bit          IRQ_AUTO_CLR = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             alu_clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_grp,
  input  logic [1:0]       req0_op,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_grp,
  input  logic [1:0]       req1_op,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [7:0]       rsp_data,
  output logic             rsp_irq,
  output logic             alu_enable,
  output logic             alu_enable_a,
  output logic             alu_enable_b,
  output logic [1:0]       alu_op_a,
  output logic [1:0]       alu_op_b,
  output logic [7:0]       alu_in_a,
  output logic [7:0]       alu_in_b,
  output logic             alu_irq_clr,
  input  logic [7:0]       alu_out,
  input  logic             alu_irq,
  output logic             busy,
  output logic [CNT_W-1:0] irq_count
);

  state_e r_state, w_state_d;

  logic             r_id, r_busy;
  logic             r_rsp_valid, r_rsp_id, r_rsp_irq;
  logic [7:0]       r_rsp_data;
  logic             r_alu_enable, r_alu_enable_a, r_alu_enable_b, r_alu_irq_clr;
  logic [1:0]       r_alu_op_a, r_alu_op_b;
  logic [7:0]       r_alu_in_a, r_alu_in_b;
  logic [CNT_W-1:0] r_irq_count;

  logic       w_gnt_valid, w_gnt_id, w_accept, w_done, w_enter_resp;
  logic       w_grp;
  logic [1:0] w_op;
  logic [7:0] w_a, w_b;

  alu_rr_arb2 u_arb (
    .i_clk       (alu_clk),
    .i_rst       (rst),
    .i_req0      (req0_valid),
    .i_req1      (req1_valid),
    .i_done      (w_done),
    .i_done_id   (r_rsp_id),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  assign w_accept     = (r_state == StIdle) && w_gnt_valid;
  assign w_done       = (r_state == StResp) && rsp_ready;
  assign w_enter_resp = (w_state_d == StResp) && (r_state != StResp);
  assign req0_ready   = w_accept && !w_gnt_id;
  assign req1_ready   = w_accept && w_gnt_id;

  assign w_grp = w_gnt_id ? req1_grp : req0_grp;
  assign w_op  = w_gnt_id ? req1_op  : req0_op;
  assign w_a   = w_gnt_id ? req1_a   : req0_a;
  assign w_b   = w_gnt_id ? req1_b   : req0_b;

  always_ff @(posedge alu_clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:    if (w_accept) w_state_d = StIssue;
      StIssue:   w_state_d = StCapture;
      StCapture: w_state_d = (alu_irq && IRQ_AUTO_CLR) ? StClear : StResp;
      StClear:   w_state_d = StResp;
      StResp:    if (rsp_ready) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge alu_clk) begin
    if (rst) begin
      r_id           <= 1'b0;
      r_busy         <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= 1'b0;
      r_rsp_irq      <= 1'b0;
      r_rsp_data     <= '0;
      r_alu_enable   <= 1'b0;
      r_alu_enable_a <= 1'b0;
      r_alu_enable_b <= 1'b0;
      r_alu_irq_clr  <= 1'b0;
      r_alu_op_a     <= '0;
      r_alu_op_b     <= '0;
      r_alu_in_a     <= '0;
      r_alu_in_b     <= '0;
      r_irq_count    <= '0;
    end else begin
      r_busy <= (w_state_d != StIdle);
      if (w_accept) begin
        r_id           <= w_gnt_id;
        r_alu_enable   <= 1'b1;
        r_alu_enable_a <= (w_grp == GRP_A);
        r_alu_enable_b <= (w_grp == GRP_B);
        r_alu_op_a     <= (w_grp == GRP_A) ? w_op : 2'b00;
        r_alu_op_b     <= (w_grp == GRP_B) ? w_op : 2'b00;
        r_alu_in_a     <= w_a;
        r_alu_in_b     <= w_b;
      end
      if (r_state == StCapture) begin
        r_rsp_data <= alu_out;
        r_rsp_irq  <= alu_irq;
        if (alu_irq && (r_irq_count != '1)) begin
          r_irq_count <= r_irq_count + CNT_W'(1);
        end
        if (w_state_d == StClear) begin
          r_alu_irq_clr <= 1'b1;
        end
      end
      // Leaving the ALU idle while the response waits keeps alu_out at zero.
      if (w_enter_resp) begin
        r_rsp_valid    <= 1'b1;
        r_rsp_id       <= r_id;
        r_alu_enable   <= 1'b0;
        r_alu_enable_a <= 1'b0;
        r_alu_enable_b <= 1'b0;
        r_alu_irq_clr  <= 1'b0;
        r_alu_op_a     <= '0;
        r_alu_op_b     <= '0;
        r_alu_in_a     <= '0;
        r_alu_in_b     <= '0;
      end
      if (w_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_data     = r_rsp_data;
  assign rsp_irq      = r_rsp_irq;
  assign alu_enable   = r_alu_enable;
  assign alu_enable_a = r_alu_enable_a;
  assign alu_enable_b = r_alu_enable_b;
  assign alu_op_a     = r_alu_op_a;
  assign alu_op_b     = r_alu_op_b;
  assign alu_in_a     = r_alu_in_a;
  assign alu_in_b     = r_alu_in_b;
  assign alu_irq_clr  = r_alu_irq_clr;
  assign busy         = r_busy;
  assign irq_count    = r_irq_count;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed scoreboard bench for alu_op_scheduler, with a behavioural ALU per instance.
module tb_alu_op_scheduler;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       irq;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic       req0_grp = 1'b0, req1_grp = 1'b0;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_irq, busy;
  logic [7:0] rsp_data;
  logic       alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr;
  logic [1:0] alu_op_a, alu_op_b;
  logic [7:0] alu_in_a, alu_in_b, alu_out;
  logic       alu_irq;
  logic [15:0] irq_count;

  logic       nc_req0_valid = 1'b0, nc_req1_valid = 1'b0, nc_rsp_ready = 1'b0;
  logic       nc_req0_ready, nc_req1_ready, nc_rsp_valid, nc_rsp_id, nc_rsp_irq, nc_busy;
  logic [7:0] nc_rsp_data;
  logic       nc_en, nc_en_a, nc_en_b, nc_irq_clr;
  logic [1:0] nc_op_a, nc_op_b;
  logic [7:0] nc_in_a, nc_in_b, nc_alu_out;
  logic       nc_alu_irq;
  logic [15:0] nc_irq_count;

  alu_op_scheduler #(.IRQ_AUTO_CLR(1'b1), .CNT_W(16)) u_dut (
    .alu_clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_grp(req0_grp),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_grp(req1_grp),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_irq(rsp_irq),
    .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_irq_clr(alu_irq_clr), .alu_out(alu_out), .alu_irq(alu_irq),
    .busy(busy), .irq_count(irq_count)
  );

  alu_op_scheduler #(.IRQ_AUTO_CLR(1'b0), .CNT_W(16)) u_dut_nc (
    .alu_clk(clk), .rst(rst),
    .req0_valid(nc_req0_valid), .req0_ready(nc_req0_ready), .req0_grp(req0_grp),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(nc_req1_valid), .req1_ready(nc_req1_ready), .req1_grp(req1_grp),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(nc_rsp_valid), .rsp_ready(nc_rsp_ready), .rsp_id(nc_rsp_id),
    .rsp_data(nc_rsp_data), .rsp_irq(nc_rsp_irq),
    .alu_enable(nc_en), .alu_enable_a(nc_en_a), .alu_enable_b(nc_en_b),
    .alu_op_a(nc_op_a), .alu_op_b(nc_op_b), .alu_in_a(nc_in_a), .alu_in_b(nc_in_b),
    .alu_irq_clr(nc_irq_clr), .alu_out(nc_alu_out), .alu_irq(nc_alu_irq),
    .busy(nc_busy), .irq_count(nc_irq_count)
  );

  function automatic logic [7:0] alu_ref(input logic grp, input logic [1:0] op,
                                         input logic [7:0] a, input logic [7:0] b);
    if (!grp) begin
      case (op)
        2'b00:   return a & b;
        2'b01:   return ~(a & b);
        2'b10:   return a | b;
        default: return a ^ b;
      endcase
    end
    case (op)
      2'b00:   return ~(a ^ b);
      2'b01:   return a & b;
      2'b10:   return ~(a | b);
      default: return a | b;
    endcase
  endfunction

  // Behavioural ALU: registered result; interrupt when result is 0xFF with operand A MSB set.
  logic irqf = 1'b0, nc_irqf = 1'b0;
  logic [7:0] w_res, nc_res;
  assign w_res   = alu_ref(alu_enable_b, alu_enable_b ? alu_op_b : alu_op_a, alu_in_a, alu_in_b);
  assign nc_res  = alu_ref(nc_en_b, nc_en_b ? nc_op_b : nc_op_a, nc_in_a, nc_in_b);
  assign alu_irq    = irqf;
  assign nc_alu_irq = nc_irqf;

  always @(posedge clk) begin
    if (rst || alu_irq_clr || !alu_enable || !(alu_enable_a || alu_enable_b)) begin
      alu_out <= 8'h00;
      irqf    <= 1'b0;
    end else begin
      alu_out <= w_res;
      irqf    <= (w_res == 8'hFF) && alu_in_a[7];
    end
  end

  always @(posedge clk) begin
    if (rst || nc_irq_clr || !nc_en || !(nc_en_a || nc_en_b)) begin
      nc_alu_out <= 8'h00;
      nc_irqf    <= 1'b0;
    end else begin
      nc_alu_out <= nc_res;
      nc_irqf    <= (nc_res == 8'hFF) && nc_in_a[7];
    end
  end

  int   clr_cnt = 0, nc_clr_cnt = 0;
  logic both_seen = 1'b0;
  always @(negedge clk) begin
    if (alu_irq_clr === 1'b1) clr_cnt <= clr_cnt + 1;
    if (nc_irq_clr === 1'b1) nc_clr_cnt <= nc_clr_cnt + 1;
    if (alu_enable_a === 1'b1 && alu_enable_b === 1'b1) both_seen <= 1'b1;
  end

  int   n_checks = 0, n_errors = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic grp, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = alu_ref(grp, op, a, b);
    if (id) begin
      req1_grp = grp; req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_grp = grp; req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
    sb.push_back('{id: id, data: r, irq: (r == 8'hFF) && a[7]});
  endtask

  // Returns just after the accept edge, which counts as latency cycle 1.
  task automatic accept(input logic id, input string tag);
    int n = 0;
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_accept"}, 32'(n < 20), 32'd1);
    tick();
    if (id) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  task automatic cmp_rsp(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_id"}, 32'(rsp_id), 32'(e.id));
      chk({tag, "_data"}, 32'(rsp_data), 32'(e.data));
      chk({tag, "_irq"}, 32'(rsp_irq), 32'(e.irq));
    end
  endtask

  task automatic get_rsp(input int lat0, input int exp_lat, input string tag);
    int lat = lat0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    cmp_rsp(tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int   idx0, idx1, got, cyc, lat;
    logic seen;
    int   gl[$];

    repeat (2) tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id_irq", 32'({rsp_id, rsp_irq}), 32'd0);
    chk("rst_alu_ctrl", 32'({alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr}), 32'd0);
    chk("rst_irq_count", 32'(irq_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Group A AND with interrupt: ISSUE, CAPTURE, CLEAR then response.
    drive(1'b0, 1'b0, 2'b00, 8'hFF, 8'hFF);
    accept(1'b0, "t1");
    chk("t1_issue_ctrl", 32'({alu_enable, alu_enable_a, alu_enable_b}), 32'b110);
    chk("t1_issue_op_a", 32'(alu_op_a), 32'd0);
    tick();
    chk("t1_capture_irq", 32'(alu_irq), 32'd1);
    tick();
    chk("t1_clear", 32'(alu_irq_clr), 32'd1);
    get_rsp(3, 4, "t1");
    chk("t1_clr_pulses", 32'(clr_cnt), 32'd1);
    chk("t1_irq_count", 32'(irq_count), 32'd1);

    // Requester 1, no interrupt.
    drive(1'b1, 1'b0, 2'b11, 8'h0F, 8'hF0);
    accept(1'b1, "t2");
    get_rsp(1, 3, "t2");
    chk("t2_no_clr", 32'(clr_cnt), 32'd1);

    // Both requesters streaming four commands each.
    idx0 = 0; idx1 = 0; got = 0; cyc = 0;
    rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 2'(idx0), 8'hC3 + 8'(idx0), 8'h3C);
    void'(sb.pop_back());
    drive(1'b1, 1'b1, 2'(idx1), 8'h5A, 8'hA5 + 8'(idx1));
    void'(sb.pop_back());
    while (got < 8 && cyc < 200) begin
      #1;
      if (req0_valid && req0_ready) begin
        gl.push_back(0);
        drive(1'b0, 1'b0, 2'(idx0), 8'hC3 + 8'(idx0), 8'h3C);
        idx0++;
      end
      if (req1_valid && req1_ready) begin
        gl.push_back(1);
        drive(1'b1, 1'b1, 2'(idx1), 8'h5A, 8'hA5 + 8'(idx1));
        idx1++;
      end
      if (rsp_valid) begin
        cmp_rsp("t3");
        got++;
      end
      tick();
      cyc++;
      req0_valid = (idx0 < 4);
      req0_op = 2'(idx0); req0_a = 8'hC3 + 8'(idx0);
      req1_valid = (idx1 < 4);
      req1_op = 2'(idx1); req1_b = 8'hA5 + 8'(idx1);
    end
    rsp_ready = 1'b0;
    chk("t3_responses", 32'(got), 32'd8);
    chk("t3_grants", 32'(gl.size()), 32'd8);
    foreach (gl[i]) chk($sformatf("t3_grant%0d", i), 32'(gl[i]), 32'(i % 2));

    // Response back-pressure with a competing request pending.
    drive(1'b1, 1'b1, 2'b10, 8'h0A, 8'h00);
    accept(1'b1, "t4");
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    drive(1'b0, 1'b0, 2'b01, 8'h33, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_fields", 32'({rsp_id, rsp_data, rsp_irq}), 32'({sb[0].id, 8'hF5, 1'b0}));
      chk("t4_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    cmp_rsp("t4");
    tick();
    rsp_ready = 1'b0;
    chk("t4_released", 32'(rsp_valid), 32'd0);
    accept(1'b0, "t4b");
    get_rsp(1, 3, "t4b");

    // Reset while in CLEAR aborts the operation.
    drive(1'b0, 1'b0, 2'b00, 8'hFF, 8'hFF);
    accept(1'b0, "t5");
    void'(sb.pop_back());
    tick();
    tick();
    chk("t5_in_clear", 32'(alu_irq_clr), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_ctrl", 32'({alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr}), 32'd0);
    chk("t5_ops", 32'({alu_op_a, alu_op_b, alu_in_a, alu_in_b}), 32'd0);
    chk("t5_rsp_busy", 32'({rsp_valid, busy}), 32'd0);
    chk("t5_irq_count", 32'(irq_count), 32'd0);
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    chk("t5_no_rsp", 32'(seen), 32'd0);

    // Interrupt reported but not cleared when auto-clear is disabled.
    req0_grp = 1'b1; req0_op = 2'b11; req0_a = 8'hF0; req0_b = 8'h0F;
    nc_req0_valid = 1'b1;
    lat = 0;
    #1;
    while (!nc_req0_ready && lat < 20) begin
      tick();
      lat++;
    end
    chk("t6_accept", 32'(lat < 20), 32'd1);
    tick();
    nc_req0_valid = 1'b0;
    lat = 1;
    while (!nc_rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("t6_lat", 32'(lat), 32'd3);
    chk("t6_fields", 32'({nc_rsp_id, nc_rsp_data, nc_rsp_irq}), 32'({1'b0, 8'hFF, 1'b1}));
    nc_rsp_ready = 1'b1;
    tick();
    nc_rsp_ready = 1'b0;
    chk("t6_no_clr", 32'(nc_clr_cnt), 32'd0);
    chk("t6_irq_count", 32'(nc_irq_count), 32'd1);

    chk("excl_enables", 32'(both_seen), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
